// File: rtl/free_reg_list.sv
// Circular free list of physical register tags: supplies dispatch, refilled by commit,
// and head restored from a branch checkpoint on a mispredict flush.
module free_reg_list #(
    parameter int DEPTH    = 16,
    parameter int TAG_BASE = 32,
    parameter int PTR_W    = 5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Dis_FrlRead,
    output logic [5:0]       Frl_RdPhyAddr,
    output logic             Frl_Empty,
    output logic [PTR_W-1:0] Frl_HeadPtr,
    output logic [PTR_W-1:0] Frl_Count,
    input  logic             Rob_Commit,
    input  logic             Rob_CommitRegWrite,
    input  logic [5:0]       Rob_CommitPrePhyAddr,
    input  logic             Cdb_Flush,
    input  logic [PTR_W-1:0] Cdb_FrlHeadPtr
);

    logic [5:0]       r_slot [DEPTH];
    logic [PTR_W-1:0] r_hd;
    logic [PTR_W-1:0] r_tl;
    logic             w_empty;
    logic             w_alloc;
    logic             w_free;

    // Wrap bit makes hd==tl unambiguous: equal pointers always mean empty.
    assign w_empty = (r_hd == r_tl);
    assign w_alloc = Dis_FrlRead & ~w_empty & ~Cdb_Flush;
    assign w_free  = Rob_Commit & Rob_CommitRegWrite;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_slot[i] <= 6'(TAG_BASE + i);
            end
            r_hd <= '0;
            r_tl <= PTR_W'(DEPTH);
        end else begin
            if (w_free) begin
                r_slot[r_tl[PTR_W-2:0]] <= Rob_CommitPrePhyAddr;
                r_tl                    <= r_tl + PTR_W'(1);
            end
            // Flushed tags are still in their slots, so moving hd back frees them.
            if (Cdb_Flush) begin
                r_hd <= Cdb_FrlHeadPtr;
            end else if (w_alloc) begin
                r_hd <= r_hd + PTR_W'(1);
            end
        end
    end

    assign Frl_RdPhyAddr = r_slot[r_hd[PTR_W-2:0]];
    assign Frl_Empty     = w_empty;
    assign Frl_HeadPtr   = r_hd;
    assign Frl_Count     = r_tl - r_hd;

endmodule

// File: tb/tb_free_reg_list.sv
// Bench for free_reg_list: directed scenarios then random traffic, checked against a
// queue-of-free-tags model with an allocation history used to undo flushed allocations.
module tb_free_reg_list;

    logic       Clk;
    logic       Reset;
    logic       Dis_FrlRead;
    logic [5:0] Frl_RdPhyAddr;
    logic       Frl_Empty;
    logic [4:0] Frl_HeadPtr;
    logic [4:0] Frl_Count;
    logic       Rob_Commit;
    logic       Rob_CommitRegWrite;
    logic [5:0] Rob_CommitPrePhyAddr;
    logic       Cdb_Flush;
    logic [4:0] Cdb_FrlHeadPtr;

    free_reg_list #(.DEPTH(16), .TAG_BASE(32), .PTR_W(5)) dut (
        .Clk                 (Clk),
        .Reset               (Reset),
        .Dis_FrlRead         (Dis_FrlRead),
        .Frl_RdPhyAddr       (Frl_RdPhyAddr),
        .Frl_Empty           (Frl_Empty),
        .Frl_HeadPtr         (Frl_HeadPtr),
        .Frl_Count           (Frl_Count),
        .Rob_Commit          (Rob_Commit),
        .Rob_CommitRegWrite  (Rob_CommitRegWrite),
        .Rob_CommitPrePhyAddr(Rob_CommitPrePhyAddr),
        .Cdb_Flush           (Cdb_Flush),
        .Cdb_FrlHeadPtr      (Cdb_FrlHeadPtr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;

    // Reference model: free tags in handout order, tags handed out in order, head index.
    int q[$];
    int hist[$];
    int m_hd;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        hist.delete();
        for (int i = 0; i < 16; i++) q.push_back(32 + i);
        m_hd = 0;
    endtask

    task automatic model_step(input bit dis, input bit free, input int tag,
                              input bit fl, input int ck);
        if (fl) begin
            int back = (m_hd - ck) & 31;
            repeat (back) q.push_front(hist.pop_back());
            m_hd = ck;
        end else if (dis && q.size() > 0) begin
            hist.push_back(q.pop_front());
            m_hd = (m_hd + 1) & 31;
        end
        if (free) q.push_back(tag);
    endtask

    task automatic check_model();
        chk("count", int'(Frl_Count), q.size());
        chk("empty", int'(Frl_Empty), (q.size() == 0) ? 1 : 0);
        chk("headptr", int'(Frl_HeadPtr), m_hd);
        chk("count_le_depth", (Frl_Count <= 5'd16) ? 1 : 0, 1);
        if (q.size() > 0) chk("rdtag", int'(Frl_RdPhyAddr), q[0]);
    endtask

    task automatic cyc(input bit dis, input bit com, input bit rw, input int tag,
                       input bit fl, input int ck);
        @(negedge Clk);
        Dis_FrlRead          = dis;
        Rob_Commit           = com;
        Rob_CommitRegWrite   = rw;
        Rob_CommitPrePhyAddr = 6'(tag);
        Cdb_Flush            = fl;
        Cdb_FrlHeadPtr       = 5'(ck);
        model_step(dis, com && rw, tag, fl, ck);
        @(posedge Clk);
        #1;
        check_model();
        Dis_FrlRead = 0; Rob_Commit = 0; Rob_CommitRegWrite = 0;
        Rob_CommitPrePhyAddr = 0; Cdb_Flush = 0; Cdb_FrlHeadPtr = 0;
    endtask

    // Asserts reset between edges; outputs are checked before any clock edge follows.
    task automatic do_reset();
        @(negedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        model_reset();
        check_model();
        chk("rst_tag", int'(Frl_RdPhyAddr), 32);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        Dis_FrlRead = 0; Rob_Commit = 0; Rob_CommitRegWrite = 0;
        Rob_CommitPrePhyAddr = 0; Cdb_Flush = 0; Cdb_FrlHeadPtr = 0;
        model_reset();
        #12;
        Reset = 1'b0;
        #1;
        check_model();
        chk("rst_tag", int'(Frl_RdPhyAddr), 32);
        chk("rst_count", int'(Frl_Count), 16);

        // Drain the whole list in order.
        for (int i = 0; i < 16; i++) begin
            chk("drain_tag", int'(Frl_RdPhyAddr), 32 + i);
            cyc(1, 0, 0, 0, 0, 0);
        end
        chk("drain_empty", int'(Frl_Empty), 1);
        chk("drain_hd", int'(Frl_HeadPtr), 16);
        chk("drain_cnt", int'(Frl_Count), 0);

        // Reads while empty are ignored; a free becomes visible the next cycle.
        repeat (3) cyc(1, 0, 0, 0, 0, 0);
        chk("emptyrd_hd", int'(Frl_HeadPtr), 16);
        chk("emptyrd_cnt", int'(Frl_Count), 0);
        cyc(0, 1, 1, 5, 0, 0);
        chk("refill_tag", int'(Frl_RdPhyAddr), 5);
        chk("refill_empty", int'(Frl_Empty), 0);
        chk("refill_cnt", int'(Frl_Count), 1);

        // Full list: allocate and free together; the freed tag lands in slot 0.
        do_reset();
        cyc(1, 1, 1, 7, 0, 0);
        chk("full_cnt", int'(Frl_Count), 16);
        chk("full_tag", int'(Frl_RdPhyAddr), 33);
        repeat (15) cyc(1, 0, 0, 0, 0, 0);
        chk("full_slot0", int'(Frl_RdPhyAddr), 7);

        // Checkpoint at hd=2, allocate three more, flush with a read in the flush cycle.
        do_reset();
        repeat (2) cyc(1, 0, 0, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 0, 0, 0);
        chk("pre_flush_tag", int'(Frl_RdPhyAddr), 37);
        cyc(1, 0, 0, 0, 1, 2);
        chk("flush_hd", int'(Frl_HeadPtr), 2);
        chk("flush_tag", int'(Frl_RdPhyAddr), 34);
        chk("flush_cnt", int'(Frl_Count), 14);

        // Flush to 3 together with a free while tl=16.
        repeat (3) cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 9, 1, 3);
        chk("flfree_hd", int'(Frl_HeadPtr), 3);
        chk("flfree_cnt", int'(Frl_Count), 14);
        repeat (13) cyc(1, 0, 0, 0, 0, 0);
        chk("flfree_slot0", int'(Frl_RdPhyAddr), 9);

        // Reach hd=21, tl=30, then reset mid-stream.
        for (int k = 0; k < 13; k++) cyc(0, 1, 1, 20 + k, 0, 0);
        repeat (5) cyc(1, 0, 0, 0, 0, 0);
        chk("mid_hd", int'(Frl_HeadPtr), 21);
        chk("mid_cnt", int'(Frl_Count), 9);
        do_reset();
        chk("midrst_hd", int'(Frl_HeadPtr), 0);
        chk("midrst_cnt", int'(Frl_Count), 16);
        chk("midrst_empty", int'(Frl_Empty), 0);

        // Random legal traffic.
        for (int n = 0; n < 3000; n++) begin
            bit dis, com, rw, fl, alloc;
            int tag, maxback, back, ck;
            fl    = ($urandom % 8) == 0;
            dis   = $urandom % 2;
            com   = $urandom % 2;
            rw    = ($urandom % 4) != 0;
            tag   = $urandom % 64;
            alloc = dis && !fl && (q.size() > 0);
            if (com && rw && (q.size() - int'(alloc) + 1 > 16)) rw = 0;
            ck = m_hd;
            if (fl) begin
                maxback = 16 - q.size() - int'(com && rw);
                if (maxback > hist.size()) maxback = hist.size();
                back = (maxback > 0) ? $urandom_range(maxback, 0) : 0;
                ck = (m_hd - back) & 31;
            end
            cyc(dis, com, rw, tag, fl, ck);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
